// File: rtl/gpr_write_port_arbiter_pkg.sv
// ============================================================================
// gpr_write_port_arbiter_pkg: shared widths, register-file constants and the
// state/source encodings used by the GPR write port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gpr_write_port_arbiter_pkg;

    localparam int c_data_width   = 32;
    localparam int c_address_size = 5;
    localparam int c_reg_count    = 2 ** c_address_size;
    localparam int c_zero_reg     = 0;

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_STARVED = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_WB     = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } write_src_t;

endpackage

`default_nettype wire

// File: rtl/gpr_write_port_arbiter_if.sv
// ============================================================================
// gpr_write_port_arbiter_if: producer-side and register-file-side signals of
// the GPR write port arbiter, with master (producers) and slave (arbiter) views.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface gpr_write_port_arbiter_if
    import gpr_write_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = c_data_width,
    parameter int ADDRESS_SIZE = c_address_size,
    parameter int FIFO_DEPTH   = 4
);

    logic                               wb_write_enable;
    logic [ADDRESS_SIZE-1:0]            wb_write_address;
    logic [DATA_WIDTH-1:0]              wb_write_data;
    logic                               mc_valid;
    logic                               mc_ready;
    logic [ADDRESS_SIZE-1:0]            mc_address;
    logic [DATA_WIDTH-1:0]              mc_data;
    logic                               mc_issue;
    logic [ADDRESS_SIZE-1:0]            mc_issue_address;
    logic                               write_enable;
    logic [ADDRESS_SIZE-1:0]            write_address;
    logic [DATA_WIDTH-1:0]              write_data;
    logic [(2**ADDRESS_SIZE)-1:0]       busy_mask;
    logic                               stall_request;
    logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;

    modport master (
        output wb_write_enable, wb_write_address, wb_write_data,
        output mc_valid, mc_address, mc_data, mc_issue, mc_issue_address,
        input  mc_ready, write_enable, write_address, write_data,
        input  busy_mask, stall_request, fifo_count
    );

    modport slave (
        input  wb_write_enable, wb_write_address, wb_write_data,
        input  mc_valid, mc_address, mc_data, mc_issue, mc_issue_address,
        output mc_ready, write_enable, write_address, write_data,
        output busy_mask, stall_request, fifo_count
    );

endinterface

`default_nettype wire

// File: rtl/gpr_write_port_arbiter_fifo.sv
// ============================================================================
// gpr_write_port_arbiter_fifo: small in-order queue of {address,data} entries
// for multi-cycle results waiting for the write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpr_write_port_arbiter_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_push,
    input  wire logic                          i_pop,
    input  wire logic [WIDTH-1:0]              i_data,
    output logic      [WIDTH-1:0]              o_head,
    output logic                               o_full,
    output logic                               o_empty,
    output logic      [$clog2(DEPTH+1)-1:0]    o_count
);

    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_count_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_count_w-1:0] r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == c_count_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_count_w'(1);
                2'b01:   r_count <= r_count - c_count_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpr_write_port_arbiter.sv
// ============================================================================
// gpr_write_port_arbiter: merges pipeline writeback and queued multi-cycle
// results onto the single GPR write port; tracks pending multi-cycle writes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpr_write_port_arbiter
    import gpr_write_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = c_data_width,
    parameter int ADDRESS_SIZE = c_address_size,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic                  system_clock,
    input  wire logic                  reset,
    gpr_write_port_arbiter_if.slave    bus
);

    localparam int c_count_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_age_w   = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
    localparam int c_entry_w = ADDRESS_SIZE + DATA_WIDTH;
    localparam int c_regs    = 2 ** ADDRESS_SIZE;
    localparam logic [c_age_w-1:0]      c_age_max = c_age_w'(STARVE_LIMIT - 1);
    localparam logic [ADDRESS_SIZE-1:0] c_zero    = ADDRESS_SIZE'(c_zero_reg);

    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [c_count_w-1:0]    w_count;
    logic [c_entry_w-1:0]    w_head;
    logic                    w_wb_sel;
    logic                    w_mc_fire;
    logic                    w_mc_nonzero;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_bypass;
    write_src_t              w_src;
    logic [ADDRESS_SIZE-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [c_regs-1:0]       w_set;
    logic [c_regs-1:0]       w_clear;
    logic                    w_issue_conflict;

    arb_state_t              r_state;
    logic                    r_stall_request;
    logic [c_age_w-1:0]      r_age;
    logic                    r_write_enable;
    logic [ADDRESS_SIZE-1:0] r_write_address;
    logic [DATA_WIDTH-1:0]   r_write_data;
    logic [c_regs-1:0]       r_busy_mask;

    gpr_write_port_arbiter_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (system_clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({bus.mc_address, bus.mc_data}),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    // Writes to r0 are accepted by the handshake but never reach the port or queue.
    assign w_wb_sel     = bus.wb_write_enable & (bus.wb_write_address != c_zero);
    assign w_mc_fire    = bus.mc_valid & ~w_fifo_full;
    assign w_mc_nonzero = (bus.mc_address != c_zero);
    assign w_pop        = ~w_fifo_empty & ~w_wb_sel;
    assign w_bypass     = w_fifo_empty & ~w_wb_sel & w_mc_fire & w_mc_nonzero;
    assign w_push       = w_mc_fire & w_mc_nonzero & ~w_bypass;

    always_comb begin
        w_src      = SRC_NONE;
        w_sel_addr = bus.wb_write_address;
        w_sel_data = bus.wb_write_data;
        if (w_wb_sel) begin
            w_src = SRC_WB;
        end else if (w_pop) begin
            w_src                    = SRC_FIFO;
            {w_sel_addr, w_sel_data} = w_head;
        end else if (w_bypass) begin
            w_src      = SRC_BYPASS;
            w_sel_addr = bus.mc_address;
            w_sel_data = bus.mc_data;
        end
    end

    assign w_set   = (bus.mc_issue && (bus.mc_issue_address != c_zero))
                   ? (c_regs'(1) << bus.mc_issue_address) : '0;
    assign w_clear = ((w_src == SRC_FIFO) || (w_src == SRC_BYPASS))
                   ? (c_regs'(1) << w_sel_addr) : '0;
    assign w_issue_conflict = |(w_set & r_busy_mask & ~w_clear);

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
            r_busy_mask     <= '0;
        end else begin
            r_write_enable <= (w_src != SRC_NONE);
            if (w_src != SRC_NONE) begin
                r_write_address <= w_sel_addr;
                r_write_data    <= w_sel_data;
            end
            r_busy_mask <= (r_busy_mask & ~w_clear) | w_set;
        end
    end

    // The empty-FIFO exit covers a starve that fires on the same cycle the last entry drains.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            r_state         <= ST_NORMAL;
            r_stall_request <= 1'b0;
            r_age           <= '0;
        end else begin
            if (w_fifo_empty || w_pop) begin
                r_age <= '0;
            end else if (r_age != c_age_max) begin
                r_age <= r_age + c_age_w'(1);
            end
            case (r_state)
                ST_NORMAL: begin
                    if ((r_age == c_age_max) || w_fifo_full) begin
                        r_state         <= ST_STARVED;
                        r_stall_request <= 1'b1;
                    end
                end
                ST_STARVED: begin
                    if (w_fifo_empty || (w_pop && (w_count <= c_count_w'(1)))) begin
                        r_state         <= ST_NORMAL;
                        r_stall_request <= 1'b0;
                    end
                end
                default: begin
                    r_state         <= ST_NORMAL;
                    r_stall_request <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mc_ready      = ~w_fifo_full;
    assign bus.write_enable  = r_write_enable;
    assign bus.write_address = r_write_address;
    assign bus.write_data    = r_write_data;
    assign bus.busy_mask     = r_busy_mask;
    assign bus.stall_request = r_stall_request;
    assign bus.fifo_count    = w_count;

    a_issue_not_busy: assert property (@(posedge system_clock) disable iff (reset)
        !w_issue_conflict);

    a_wb_honours_stall: assert property (@(posedge system_clock) disable iff (reset)
        r_stall_request |=> !bus.wb_write_enable);

endmodule

`default_nettype wire
